// File: rtl/sc_timing_monitor.sv
// Self-composition timing monitor: timestamps each RSA copy's finish and flags
// timing divergence (leak), wrong decryptions (data_err) and hangs (timeout).
module sc_timing_monitor #(
    parameter int NCOPY   = 2,
    parameter int MW      = 16,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  assume_ok,
    input  logic [NCOPY-1:0]      finish,
    input  logic [NCOPY*MW-1:0]   m_out,
    input  logic [MW-1:0]         m_ref,
    output logic                  busy,
    output logic                  done,
    output logic                  leak,
    output logic                  data_err,
    output logic                  timeout,
    output logic                  rejected,
    output logic [NCOPY-1:0]      fin_mask,
    output logic [NCOPY-1:0]      err_mask,
    output logic [CW-1:0]         first_cyc,
    output logic [CW-1:0]         skew
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [NCOPY-1:0] fin_mask_d, err_mask_d;
    logic [CW-1:0]    first_cyc_d, skew_d;
    logic             leak_d, data_err_d, timeout_d, rejected_d;

    logic [NCOPY-1:0] ev, mismatch, fin_next;

    // Finish events exist only in RUN; a copy's level after its event is ignored.
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NCOPY; i++) begin
            mismatch[i] = (m_out[i*MW +: MW] != m_ref);
        end
        ev       = (state == RUN) ? (finish & ~fin_mask) : '0;
        fin_next = fin_mask | ev;
    end

    // NOTE: every next-state signal gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        fin_mask_d  = fin_mask;
        err_mask_d  = err_mask;
        first_cyc_d = first_cyc;
        skew_d      = skew;
        leak_d      = leak;
        data_err_d  = data_err;
        timeout_d   = timeout;
        rejected_d  = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start && assume_ok) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    fin_mask_d  = '0;
                    err_mask_d  = '0;
                    first_cyc_d = '0;
                    skew_d      = '0;
                    leak_d      = 1'b0;
                    data_err_d  = 1'b0;
                    timeout_d   = 1'b0;
                end else if (start) begin
                    rejected_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d      = cnt + CW'(1);
                fin_mask_d = fin_next;
                err_mask_d = err_mask | (ev & mismatch);
                if (|(ev & mismatch)) begin
                    data_err_d = 1'b1;
                end
                // An empty fin_mask means these are the run's first finish events.
                if (|ev) begin
                    if (fin_mask == '0) begin
                        first_cyc_d = cnt;
                    end else if (cnt != first_cyc) begin
                        leak_d = 1'b1;
                        skew_d = cnt - first_cyc;
                    end
                end
                if (&fin_next) begin
                    state_d = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    if (|fin_next) begin
                        leak_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fin_mask  <= '0;
            err_mask  <= '0;
            first_cyc <= '0;
            skew      <= '0;
            leak      <= 1'b0;
            data_err  <= 1'b0;
            timeout   <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            fin_mask  <= fin_mask_d;
            err_mask  <= err_mask_d;
            first_cyc <= first_cyc_d;
            skew      <= skew_d;
            leak      <= leak_d;
            data_err  <= data_err_d;
            timeout   <= timeout_d;
            rejected  <= rejected_d;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sc_timing_monitor.sv
// Directed bench for sc_timing_monitor: each run's expected results come from a
// small two-copy model, queued at stimulus time and compared when done rises.
module tb_sc_timing_monitor;

    localparam int NCOPY   = 2;
    localparam int MW      = 16;
    localparam int CW      = 16;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 100000;
    localparam logic [MW-1:0] REF = 16'h1234;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                assume_ok;
    logic [NCOPY-1:0]    finish;
    logic [NCOPY*MW-1:0] m_out;
    logic [MW-1:0]       m_ref;
    logic                busy, done, leak, data_err, timeout, rejected;
    logic [NCOPY-1:0]    fin_mask, err_mask;
    logic [CW-1:0]       first_cyc, skew;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         end_cyc;
        logic       leak;
        logic       data_err;
        logic       timeout;
        logic [1:0] fin_mask;
        logic [1:0] err_mask;
        int         first_cyc;
        int         skew;
    } exp_t;

    exp_t sb[$];

    sc_timing_monitor #(
        .NCOPY(NCOPY), .MW(MW), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .assume_ok(assume_ok),
        .finish(finish), .m_out(m_out), .m_ref(m_ref),
        .busy(busy), .done(done), .leak(leak), .data_err(data_err),
        .timeout(timeout), .rejected(rejected), .fin_mask(fin_mask),
        .err_mask(err_mask), .first_cyc(first_cyc), .skew(skew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_leak"},      32'(leak),      0);
        check({tag, "_data_err"},  32'(data_err),  0);
        check({tag, "_timeout"},   32'(timeout),   0);
        check({tag, "_rejected"},  32'(rejected),  0);
        check({tag, "_fin_mask"},  32'(fin_mask),  0);
        check({tag, "_err_mask"},  32'(err_mask),  0);
        check({tag, "_first_cyc"}, 32'(first_cyc), 0);
        check({tag, "_skew"},      32'(skew),      0);
    endtask

    // Independent two-copy model of one run's final results.
    function automatic exp_t model(input int f0, input int f1,
                                   input logic [MW-1:0] m0, input logic [MW-1:0] m1);
        exp_t e;
        bit   d0 = (f0 < TIMEOUT);
        bit   d1 = (f1 < TIMEOUT);
        bit   all_fin = d0 && d1;
        e.end_cyc   = all_fin ? ((f0 > f1) ? f0 : f1) : TIMEOUT - 1;
        e.timeout   = !all_fin;
        e.leak      = all_fin ? (f0 != f1) : (d0 || d1);
        e.skew      = all_fin ? ((f0 > f1) ? f0 - f1 : f1 - f0) : 0;
        e.first_cyc = all_fin ? ((f0 < f1) ? f0 : f1) : (d0 ? f0 : (d1 ? f1 : 0));
        e.fin_mask  = {d1, d0};
        e.err_mask  = {d1 && (m1 != REF), d0 && (m0 != REF)};
        e.data_err  = |e.err_mask;
        return e;
    endfunction

    task automatic run_case(input string name, input int f0, input int f1,
                            input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                            input bit poke_start);
        exp_t e;
        bit   seen = 0;
        int   dc   = -1;
        sb.push_back(model(f0, f1, m0, m1));
        start = 1'b1; assume_ok = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_run"}, 32'(busy), 1);
        for (int c = 0; c < 200; c++) begin
            finish = {(c >= f1), (c >= f0)};
            m_out  = {m1, m0};
            start  = poke_start && (c == 5);
            tick();
            if (done) begin
                seen = 1;
                dc   = c;
                break;
            end
        end
        start  = 1'b0;
        finish = '0;
        e = sb.pop_front();
        if (!seen) begin
            check({name, "_done_bound"}, 0, 1);
        end else begin
            check({name, "_end_cyc"},   32'(dc),        32'(e.end_cyc));
            check({name, "_busy_done"}, 32'(busy),      0);
            check({name, "_leak"},      32'(leak),      32'(e.leak));
            check({name, "_data_err"},  32'(data_err),  32'(e.data_err));
            check({name, "_timeout"},   32'(timeout),   32'(e.timeout));
            check({name, "_fin_mask"},  32'(fin_mask),  32'(e.fin_mask));
            check({name, "_err_mask"},  32'(err_mask),  32'(e.err_mask));
            check({name, "_first_cyc"}, 32'(first_cyc), 32'(e.first_cyc));
            check({name, "_skew"},      32'(skew),      32'(e.skew));
            // Results must hold while idle in DONE.
            tick(); tick();
            check({name, "_hold_done"}, 32'(done),      1);
            check({name, "_hold_skew"}, 32'(skew),      32'(e.skew));
            check({name, "_hold_fin"},  32'(fin_mask),  32'(e.fin_mask));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; assume_ok = 1'b0;
        finish = '0; m_out = '0; m_ref = REF;
        tick(); tick();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rejected start from IDLE.
        start = 1'b1; assume_ok = 1'b0;
        tick();
        start = 1'b0;
        check("rej_pulse", 32'(rejected), 1);
        check("rej_busy",  32'(busy),     0);
        check("rej_done",  32'(done),     0);
        tick();
        check("rej_clear", 32'(rejected), 0);

        run_case("same37",   37, 37, REF, REF,      1'b0);
        run_case("skew4",    37, 41, REF, REF,      1'b1);
        run_case("err20",    20, 20, REF, 16'h1235, 1'b0);
        run_case("tmo_part", 10, NEVER, REF, REF,   1'b0);
        run_case("first0",   0,  5,  16'h0000, REF, 1'b0);
        run_case("tmo_none", NEVER, NEVER, REF, REF, 1'b0);
        run_case("last_cyc", TIMEOUT - 1, TIMEOUT - 1, REF, REF, 1'b0);

        // Rejected start in DONE keeps previous results.
        start = 1'b1; assume_ok = 1'b0;
        tick();
        start = 1'b0;
        check("rejd_pulse", 32'(rejected), 1);
        check("rejd_done",  32'(done),     1);
        check("rejd_first", 32'(first_cyc), TIMEOUT - 1);

        // Reset in the middle of a run, after copy0 has already finished.
        start = 1'b1; assume_ok = 1'b1;
        tick();
        start = 1'b0;
        m_out = {REF, REF};
        for (int c = 0; c < 10; c++) begin
            finish = {1'b0, (c >= 3)};
            tick();
        end
        check("pre_rst_fin", 32'(fin_mask), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        finish = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_case("post_rst", 37, 37, REF, REF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
